// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one main-memory port between the instruction-fetch requester
//   (read-only) and the data requester (read/write). Data has priority.
//   After STARVE_MAX consecutive data grants with fetch waiting, the next
//   grant goes to fetch. A grant is registered and held until mem_done.
//   A per-transaction timeout releases a hung port.
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   i_req/i_addr        fetch request (level) and address
//   i_rdata/i_done/i_err  fetched word (held), completion / timeout pulses
//   d_req/d_we/d_ctrl/d_addr/d_wdata  data request and attributes
//   d_rdata/d_done/d_err  read data (held), completion / timeout pulses
//   mem_*               registered memory port; mem_done/mem_data_out back
//   busy                high while a transaction is outstanding
//   timeout_err         sticky timeout flag, cleared only by reset
module mem_port_arbiter #(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          CTRL_W      = 3,
  parameter logic [CTRL_W-1:0]    CTRL_WORD   = CTRL_W'(2),
  parameter int unsigned          STARVE_MAX  = 4,
  parameter int unsigned          TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_enable,
  output logic              mem_write_en,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q;
  logic [3:0]          starve_q;
  logic [15:0]         tmo_q;
  logic                mem_enable_q;
  logic                mem_write_en_q;
  logic [CTRL_W-1:0]   mem_ctrl_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_in_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                i_done_q;
  logic                i_err_q;
  logic                d_done_q;
  logic                d_err_q;
  logic                busy_q;
  logic                timeout_err_q;

  logic                grant_i_d;
  logic                grant_d_d;
  logic                starved_d;
  logic                tmo_hit_d;

  // Data wins unless fetch has waited through STARVE_MAX data grants.
  always_comb begin
    starved_d = (starve_q == 4'(STARVE_MAX));
    grant_d_d = d_req && !(i_req && starved_d);
    grant_i_d = i_req && !grant_d_d;
    // Abort on the BUSY cycle that would bring the count to TIMEOUT_CYC,
    // so enable is high for exactly TIMEOUT_CYC cycles.
    tmo_hit_d = (tmo_q == 16'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      starve_q       <= '0;
      tmo_q          <= '0;
      mem_enable_q   <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_ctrl_q     <= '0;
      mem_addr_q     <= '0;
      mem_data_in_q  <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_done_q       <= 1'b0;
      i_err_q        <= 1'b0;
      d_done_q       <= 1'b0;
      d_err_q        <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      i_err_q  <= 1'b0;
      d_done_q <= 1'b0;
      d_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_i_d) begin
            state_q        <= BUSY_I;
            mem_enable_q   <= 1'b1;
            mem_write_en_q <= 1'b0;
            mem_ctrl_q     <= CTRL_WORD;
            mem_addr_q     <= i_addr;
            mem_data_in_q  <= '0;
            busy_q         <= 1'b1;
            tmo_q          <= '0;
            starve_q       <= '0;
          end else if (grant_d_d) begin
            state_q        <= BUSY_D;
            mem_enable_q   <= 1'b1;
            mem_write_en_q <= d_we;
            mem_ctrl_q     <= d_ctrl;
            mem_addr_q     <= d_addr;
            mem_data_in_q  <= d_wdata;
            busy_q         <= 1'b1;
            tmo_q          <= '0;
            if (i_req && !starved_d) begin
              starve_q <= starve_q + 4'd1;
            end
          end else begin
            // No grant implies i_req is low.
            starve_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_done) begin
            state_q        <= IDLE;
            mem_enable_q   <= 1'b0;
            mem_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
            if (state_q == BUSY_I) begin
              i_rdata_q <= mem_data_out;
              i_done_q  <= 1'b1;
            end else begin
              if (!mem_write_en_q) begin
                d_rdata_q <= mem_data_out;
              end
              d_done_q <= 1'b1;
            end
          end else if (tmo_hit_d) begin
            state_q        <= IDLE;
            mem_enable_q   <= 1'b0;
            mem_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b1;
            if (state_q == BUSY_I) begin
              i_err_q <= 1'b1;
            end else begin
              d_err_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_enable   = mem_enable_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_ctrl     = mem_ctrl_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_done       = i_done_q;
  assign i_err        = i_err_q;
  assign d_done       = d_done_q;
  assign d_err        = d_err_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule
